// File: rtl/fnd_ctrl.sv
// Four-digit common-anode 7-segment scanner for watch/stopwatch time fields.
// Shows SS.CC or HH.MM, blinks the dot from msec and blanks the field under edit.
module fnd_ctrl #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int SCAN_HZ  = 1000,
    parameter int BLINK_HZ = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_mode,
    input  logic [1:0] i_edit,
    input  logic [6:0] msec,
    input  logic [5:0] sec,
    input  logic [5:0] min,
    input  logic [4:0] hour,
    output logic [3:0] fnd_com,
    output logic [7:0] fnd_data
);

    localparam int DIV       = CLK_FREQ / SCAN_HZ;
    localparam int BLINK_DIV = CLK_FREQ / (2 * BLINK_HZ);
    localparam int SCAN_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BLINK_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    localparam logic [1:0] EDIT_SEC  = 2'b01;
    localparam logic [1:0] EDIT_MIN  = 2'b10;
    localparam logic [1:0] EDIT_HOUR = 2'b11;

    // Field values are reduced mod 100 before being split into digits.
    function automatic logic [6:0] mod100(input logic [6:0] v);
        return (v >= 7'd100) ? 7'(v - 7'd100) : v;
    endfunction

    function automatic logic [3:0] tens_of(input logic [6:0] v);
        return 4'(mod100(v) / 7'd10);
    endfunction

    function automatic logic [3:0] ones_of(input logic [6:0] v);
        return 4'(mod100(v) % 7'd10);
    endfunction

    // Active-low gfedcba pattern; codes above 9 cannot occur and stay dark.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    logic [SCAN_W-1:0]  scan_cnt;
    logic [BLINK_W-1:0] blink_cnt;
    logic [1:0]         digit_sel;
    logic               blink_phase;
    logic               tick;
    logic               blink_tick;

    assign tick       = (scan_cnt == SCAN_LAST);
    assign blink_tick = (blink_cnt == BLINK_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_cnt  <= '0;
            digit_sel <= 2'd0;
        end else begin
            scan_cnt  <= tick ? '0 : SCAN_W'(scan_cnt + 1'b1);
            digit_sel <= tick ? 2'(digit_sel + 2'd1) : digit_sel;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            blink_cnt   <= blink_tick ? '0 : BLINK_W'(blink_cnt + 1'b1);
            blink_phase <= blink_tick ? ~blink_phase : blink_phase;
        end
    end

    // Stage p0: digit selection, segment decode, dot and edit blanking.
    // digit_sel[1] picks the left field pair, digit_sel[0] picks its tens digit.
    logic [6:0] hi_field_p0;
    logic [6:0] lo_field_p0;
    logic [6:0] field_p0;
    logic [3:0] digit_p0;
    logic       dp_n_p0;
    logic       blank_p0;
    logic [3:0] com_p0;
    logic [7:0] data_p0;

    always_comb begin
        hi_field_p0 = i_mode ? 7'(hour) : 7'(sec);
        lo_field_p0 = i_mode ? 7'(min)  : msec;
        field_p0    = digit_sel[1] ? hi_field_p0 : lo_field_p0;
        digit_p0    = digit_sel[0] ? tens_of(field_p0) : ones_of(field_p0);
        dp_n_p0     = !((digit_sel == 2'd2) && (msec < 7'd50));

        blank_p0 = 1'b0;
        if (blink_phase) begin
            case (i_edit)
                EDIT_SEC:  blank_p0 = !i_mode &&  digit_sel[1];
                EDIT_MIN:  blank_p0 =  i_mode && !digit_sel[1];
                EDIT_HOUR: blank_p0 =  i_mode &&  digit_sel[1];
                default:   blank_p0 = 1'b0;
            endcase
        end

        com_p0  = ~(4'b0001 << digit_sel);
        data_p0 = blank_p0 ? 8'hFF : {dp_n_p0, seg7(digit_p0)};
    end

    // Stage p1: registered display drive.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fnd_com  <= 4'b1111;
            fnd_data <= 8'hFF;
        end else begin
            fnd_com  <= com_p0;
            fnd_data <= data_p0;
        end
    end

endmodule

// File: tb/tb_fnd_ctrl.sv
// Directed bench for fnd_ctrl with DIV=4 and a blink toggle every 4 cycles,
// so each digit slot spans 4 clocks and blink_phase alternates per slot.
module tb_fnd_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       i_mode = 1'b0;
    logic [1:0] i_edit = 2'b00;
    logic [6:0] msec = 7'd0;
    logic [5:0] sec = 6'd0;
    logic [5:0] min = 6'd0;
    logic [4:0] hour = 5'd0;
    logic [3:0] fnd_com;
    logic [7:0] fnd_data;

    int checks = 0;
    int errors = 0;

    fnd_ctrl #(
        .CLK_FREQ(1000),
        .SCAN_HZ (250),
        .BLINK_HZ(125)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .i_mode  (i_mode),
        .i_edit  (i_edit),
        .msec    (msec),
        .sec     (sec),
        .min     (min),
        .hour    (hour),
        .fnd_com (fnd_com),
        .fnd_data(fnd_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got com=%b data=%h expected com=%b data=%h",
                     tag, got[11:8], got[7:0], exp[11:8], exp[7:0]);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        @(negedge clk);
        chk("reset", {fnd_com, fnd_data}, {4'b1111, 8'hFF});
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic steps(input int n, input string tag, input logic [3:0] com, input logic [7:0] data);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            chk(tag, {fnd_com, fnd_data}, {com, data});
        end
    endtask

    task automatic slot(input string tag, input logic [3:0] com, input logic [7:0] data);
        steps(4, tag, com, data);
    endtask

    initial begin
        // 1: SS.CC = 12.34
        i_mode = 1'b0; i_edit = 2'b00; sec = 6'd12; msec = 7'd34;
        apply_reset();
        slot("t1_d0", 4'b1110, 8'h99);
        slot("t1_d1", 4'b1101, 8'hB0);
        slot("t1_d2", 4'b1011, 8'h24);
        slot("t1_d3", 4'b0111, 8'hF9);
        slot("t1_wrap", 4'b1110, 8'h99);

        // 2: HH.MM = 23.05, then dot off, then hour edit
        i_mode = 1'b1; hour = 5'd23; min = 6'd5; msec = 7'd34;
        apply_reset();
        slot("t2_d0", 4'b1110, 8'h92);
        slot("t2_d1", 4'b1101, 8'hC0);
        slot("t2_d2", 4'b1011, 8'h30);
        slot("t2_d3", 4'b0111, 8'hA4);
        msec = 7'd60;
        slot("t2_d0b", 4'b1110, 8'h92);
        slot("t2_d1b", 4'b1101, 8'hC0);
        slot("t2_d2_nodp", 4'b1011, 8'hB0);
        slot("t2_d3b", 4'b0111, 8'hA4);
        i_edit = 2'b11;
        slot("t2h_d0", 4'b1110, 8'h92);
        slot("t2h_d1", 4'b1101, 8'hC0);
        slot("t2h_d2", 4'b1011, 8'hB0);
        slot("t2h_d3_blank", 4'b0111, 8'hFF);

        // 3: editing seconds in mode 0
        i_mode = 1'b0; i_edit = 2'b01; sec = 6'd59; msec = 7'd0;
        apply_reset();
        for (int s = 0; s < 2; s++) begin
            slot("t3_d0", 4'b1110, 8'hC0);
            slot("t3_d1", 4'b1101, 8'hC0);
            slot("t3_d2", 4'b1011, 8'h10);
            slot("t3_d3_blank", 4'b0111, 8'hFF);
        end

        // 4: min edit has no effect in mode 0; mid-slot switch to mode 1
        i_mode = 1'b0; i_edit = 2'b10; sec = 6'd59; msec = 7'd0; hour = 5'd23; min = 6'd5;
        apply_reset();
        slot("t4_d0", 4'b1110, 8'hC0);
        slot("t4_d1", 4'b1101, 8'hC0);
        slot("t4_d2", 4'b1011, 8'h10);
        slot("t4_d3", 4'b0111, 8'h92);
        steps(2, "t4_pre", 4'b1110, 8'hC0);
        i_mode = 1'b1;
        steps(2, "t4_sw", 4'b1110, 8'h92);
        slot("t4_d1_blank", 4'b1101, 8'hFF);
        slot("t4_d2m1", 4'b1011, 8'h30);
        slot("t4_d3m1", 4'b0111, 8'hA4);

        // 5: out-of-range msec reduced mod 100
        i_mode = 1'b0; i_edit = 2'b00; sec = 6'd12; msec = 7'd127;
        apply_reset();
        slot("t5_d0", 4'b1110, 8'hF8);
        slot("t5_d1", 4'b1101, 8'hA4);

        // 6: asynchronous reset while digit 2 is showing
        msec = 7'd34;
        apply_reset();
        slot("t6_d0", 4'b1110, 8'h99);
        slot("t6_d1", 4'b1101, 8'hB0);
        steps(1, "t6_d2", 4'b1011, 8'h24);
        rst = 1'b0;
        #1;
        chk("t6_async", {fnd_com, fnd_data}, {4'b1111, 8'hFF});
        @(negedge clk);
        rst = 1'b1;
        slot("t6_restart", 4'b1110, 8'h99);
        slot("t6_d1b", 4'b1101, 8'hB0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fnd_ctrl.md
Name: fnd_ctrl

Overview:
- Display-side consumer of the watch/stopwatch time outputs (msec, sec, min, hour).
- Converts the selected pair of fields to decimal digits and time-multiplexes them onto a 4-digit, common-anode 7-segment display.
- Drives a 50%-duty dot blink from msec.
- Blanks the field being edited at a blink rate so the user sees which field the Up/Down buttons adjust.

Parameters:
- CLK_FREQ, 100_000_000, input clock frequency in Hz.
- SCAN_HZ, 1000, digit advance rate in Hz. Scan divider DIV = CLK_FREQ/SCAN_HZ; must be ≥ 2.
- BLINK_HZ, 2, edit-blink frequency in Hz. Blink phase toggles every CLK_FREQ/(2*BLINK_HZ) cycles.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-low
- i_mode  input  1  0 = SS.CC display (sec, msec); 1 = HH.MM display (hour, min)
- i_edit  input  2  field under edit: 00 none, 01 sec, 10 min, 11 hour
- msec  input  7  centiseconds, 0-99
- sec  input  6  0-59
- min  input  6  0-59
- hour  input  5  0-23
- fnd_com  output  4  digit enables, active-low; bit0 = rightmost digit
- fnd_data  output  8  {dp, g,f,e,d,c,b,a}, all active-low

Behaviour:
- Reset (rst=0, async):
  - fnd_com=4'b1111, fnd_data=8'hFF.
  - Scan counter=0, digit_sel=0, blink counter=0, blink_phase=0.
- Scan divider:
  - Counts 0..DIV-1, then wraps to 0.
  - tick pulses for one cycle when count==DIV-1.
  - On tick, digit_sel (2 bits) increments and wraps 3→0.
- Outputs are registered every clock from the current digit_sel, mode, edit, blink_phase and time inputs. Latency is one cycle.
- The first clock edge after reset release gives fnd_com=4'b1110 (digit0).
- Digit source:
  - Mode 0: d3=sec/10, d2=sec%10, d1=msec/10, d0=msec%10.
  - Mode 1: d3=hour/10, d2=hour%10, d1=min/10, d0=min%10.
- Out-of-range inputs: each field is reduced mod 100 before splitting, so msec=127 shows "27". No other clamping.
- Segment code (gfedcba, active-low): 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90 (hex).
- Dot:
  - Lit (bit7=0) only on digit2, and only while msec<50.
  - Otherwise bit7=1.
  - Same rule in both modes.
- fnd_com is one-hot-low on digit_sel: 0→1110, 1→1101, 2→1011, 3→0111.
- Edit blink:
  - The blink counter runs continuously.
  - Blanking condition: blink_phase=1 and the current digit belongs to the edited field in the current mode. sec → d3/d2 in mode 0; min → d1/d0 in mode 1; hour → d3/d2 in mode 1.
  - When blanking: fnd_data=8'hFF, including dp.
  - An edited field not shown in the current mode (e.g. min in mode 0, sec in mode 1) has no effect.
  - i_edit=00 never blanks.
- Mode or edit change mid-scan: applies on the next clock to the current digit. Scan position and blink phase are not reset.
- Input changes within a digit slot: reflected the next clock. No input latching.
- Simultaneous tick and blink toggle: both take effect. The output the following clock uses the new digit_sel and the new blink_phase.
- Reset asserted mid-scan: outputs return to all-ones immediately (asynchronous). Counters restart from 0 on release.

Test Plan:
All scenarios use CLK_FREQ=1000, SCAN_HZ=250 (DIV=4) and BLINK_HZ=125 (blink toggle every 4 cycles).
1. Reset, then release with mode=0, edit=00, sec=12, msec=34:
   - Cycle 1: fnd_com=1110, fnd_data=99.
   - After tick: 1101/B0.
   - Then 1011 with fnd_data=24 (dp lit, since 34<50).
   - Then 0111/F9, then back to 1110.
2. mode=1, hour=23, min=5:
   - Digits over one scan: d0=92, d1=C0, d2=B0 (with dp only if msec<50), d3=A4.
   - Set msec=60: digit2 fnd_data becomes B0 (dp off).
3. mode=0, edit=01, sec=59, msec=0:
   - d3/d2 read 8'hFF whenever blink_phase=1, and 92/10 (dp lit) when blink_phase=0.
   - d1/d0 always C0.
4. mode=0, edit=10:
   - No digit is ever blanked.
   - Switch mode to 1: d1/d0 blink on the next blink_phase=1 window, with no scan restart.
5. msec=127, mode=0: d1=A4, d0=F8 (mod-100 rule).
6. Assert rst mid-scan (digit_sel=2):
   - Outputs go to FF/1111 asynchronously before the next clock edge.
   - After release, the first output is digit0.
